// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed from latched operands and committed after an exact, parameterised latency.
module muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PROD_W  = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Result datapath; op_q[0] selects unsigned, op_q[1] selects divide
    logic [PROD_W-1:0]  a_ext, b_ext, prod;
    logic               a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;
    logic [WIDTH-1:0]   res_hi_c, res_lo_c;

    always_comb begin
        a_ext = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_ext = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod  = a_ext * b_ext;

        a_neg  = ~op_q[0] & a_q[WIDTH-1];
        b_neg  = ~op_q[0] & b_q[WIDTH-1];
        b_zero = (b_q == '0);
        a_mag  = a_neg ? -a_q : a_q;
        b_mag  = b_neg ? -b_q : b_q;
        // Guard the divider against zero; the zero-divisor result is substituted below
        b_div  = b_zero ? WIDTH'(1) : b_mag;
        q_mag  = a_mag / b_div;
        r_mag  = a_mag % b_div;
        quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;
        if (b_zero) begin
            quo = '1;
            rem = a_q;
        end

        if (op_q[1]) begin
            res_hi_c = rem;
            res_lo_c = quo;
        end else begin
            res_hi_c = prod[PROD_W-1:WIDTH];
            res_lo_c = prod[WIDTH-1:0];
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            op_d    = op[1:0];
                            a_d     = num1;
                            b_d     = num2;
                            cnt_d   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                            busy_d  = 1'b1;
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = num1;
                        OP_MTLO: lo_d = num1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    hi_d    = res_hi_c;
                    lo_d    = res_lo_c;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed test-plan steps plus random ops
// against a plain-arithmetic reference model of HI/LO and latency.
module tb_muldiv_unit;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned MUL_CYCLES = 5;
    localparam int unsigned DIV_CYCLES = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] num1, num2;
    logic             busy;
    logic [WIDTH-1:0] hi, lo;

    int n_checks = 0;
    int n_fails  = 0;
    logic [WIDTH-1:0] m_hi, m_lo;

    muldiv_unit #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .num1  (num1),
        .num2  (num2),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic on the architectural rules
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint          sp, sq, sr;
        longint unsigned up, uq, ur;
        eh = m_hi;
        el = m_lo;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                eh = sp[63:32];
                el = sp[31:0];
            end
            3'd1: begin
                up = {32'h0, a} * {32'h0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            3'd2, 3'd3: begin
                if (b == 32'h0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                end else if (o == 3'd2) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    eh = sr[31:0];
                    el = sq[31:0];
                end else begin
                    uq = {32'h0, a} / {32'h0, b};
                    ur = {32'h0, a} % {32'h0, b};
                    eh = ur[31:0];
                    el = uq[31:0];
                end
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endtask

    // Called at a negedge with the unit idle; returns at the negedge after the result edge
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
        logic [31:0] eh, el;
        int n;
        model(o, a, b, eh, el);
        start = 1'b1;
        op    = o;
        num1  = a;
        num2  = b;
        @(negedge clk);
        if (o < 3'd4) begin
            n = (o < 3'd2) ? MUL_CYCLES : DIV_CYCLES;
            for (int i = 0; i < n; i++) begin
                check("busy_run", 32'(busy), 32'd1);
                check("hi_hold", hi, m_hi);
                check("lo_hold", lo, m_lo);
                start = inject && (i == 1 || i == 2 || i == n - 1);
                op    = (i == 1) ? 3'd4 : ((i == 2) ? 3'd2 : 3'd0);
                num1  = (i == 1) ? 32'h1234_5678 : $urandom;
                num2  = $urandom;
                @(negedge clk);
            end
        end
        start = 1'b0;
        m_hi  = eh;
        m_lo  = el;
        check("busy_done", 32'(busy), 32'd0);
        check("hi_result", hi, m_hi);
        check("lo_result", lo, m_lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            4: return 32'(int'($urandom_range(20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        rst   = 1'b1;
        start = 1'b1;
        op    = 3'd4;
        num1  = 32'hDEAD_BEEF;
        num2  = 32'h0;
        m_hi  = '0;
        m_lo  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        rst   = 1'b0;
        start = 1'b0;

        // MULT latency and signed product
        do_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_lo_const", lo, 32'hFFFF_FFEB);

        // MULTU then DIVU back-to-back
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_hi_const", hi, 32'hFFFF_FFFE);
        check("multu_lo_const", lo, 32'h0000_0001);
        do_op(3'd3, 32'h0000_0064, 32'h0000_0007, 1'b0);
        check("divu_hi_const", hi, 32'h0000_0002);
        check("divu_lo_const", lo, 32'h0000_000E);

        // Signed divide corners
        do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_hi", hi, 32'h0000_0000);
        check("div_ovf_lo", lo, 32'h8000_0000);
        do_op(3'd2, 32'h0000_0005, 32'h0000_0000, 1'b0);
        check("div_zero_hi", hi, 32'h0000_0005);
        check("div_zero_lo", lo, 32'hFFFF_FFFF);

        // Starts during RUN are ignored, including on the final RUN cycle
        do_op(3'd0, 32'h0000_1234, 32'hFFFF_0003, 1'b1);
        check("inject_busy_idle", 32'(busy), 32'd0);

        // Reserved ops do nothing
        do_op(3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0);
        do_op(3'd7, 32'h3333_3333, 32'h4444_4444, 1'b0);

        // MTHI / MTLO
        do_op(3'd4, 32'hAAAA_5555, 32'h0, 1'b0);
        check("mthi_const", hi, 32'hAAAA_5555);
        do_op(3'd5, 32'h0000_BEEF, 32'h0, 1'b0);
        check("mtlo_const", lo, 32'h0000_BEEF);
        check("mtlo_hi_kept", hi, 32'hAAAA_5555);

        // Reset on the third RUN cycle of a DIV aborts without a write
        start = 1'b1;
        op    = 3'd2;
        num1  = 32'h0000_0064;
        num2  = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        repeat (DIV_CYCLES + 2) begin
            @(negedge clk);
            check("rst_no_late_hi", hi, 32'h0);
            check("rst_no_late_lo", lo, 32'h0);
            check("rst_no_busy", 32'(busy), 32'd0);
        end
        do_op(3'd0, 32'h0000_0003, 32'h0000_0004, 1'b0);

        // Random mix against the model
        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(7));
            ra = pick_operand();
            rb = pick_operand();
            do_op(ro, ra, rb, bit'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
